// File: rtl/hdb3_pkg.sv
// hdb3_pkg
// Definitions shared across the HDB3 link blocks.
//   state_t      : BER checker state (SEARCH / LOCKED)
//   HDB3_LFSR_W  : default m-sequence register length
//   HDB3_TAPS    : default feedback mask. The m-sequence generator at the
//                  transmit end uses the same value, so both ends stay matched.
package hdb3_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int         HDB3_LFSR_W = 7;
    localparam logic [6:0] HDB3_TAPS   = 7'h60;  // x^7 + x^6 + 1, period 127

endpackage

// File: rtl/ber_window.sv
// ber_window
// Loss-of-lock detector for the BER checker. It counts locked bits in
// windows of WIN bits and counts the errors inside the current window.
// loss is asserted combinationally on the bit that carries the LOSS_THR-th
// error of a window.
// Ports:
//   clk    in  1 : system clock
//   rst    in  1 : synchronous active-high reset
//   clear  in  1 : restart the window (asserted on lock entry)
//   bit_en in  1 : a locked bit is being checked this cycle
//   err    in  1 : that bit mismatched the replica
//   loss   out 1 : this bit reaches the error threshold
module ber_window #(
    parameter int WIN      = 64,
    parameter int LOSS_THR = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic bit_en,
    input  logic err,
    output logic loss
);

    localparam int BW = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int EW = $clog2(LOSS_THR + 1);

    logic [BW-1:0] win_bits;
    logic [EW-1:0] win_err;

    // The erroring bit counts in the current window, including the last bit
    // before a wrap.
    assign loss = bit_en && err && (win_err == EW'(LOSS_THR - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            win_bits <= '0;
            win_err  <= '0;
        end else if (bit_en) begin
            if (win_bits == BW'(WIN - 1)) begin
                win_bits <= '0;
                win_err  <= '0;
            end else begin
                win_bits <= win_bits + 1'b1;
                if (err) begin
                    win_err <= win_err + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/hdb3_ber_checker.sv
// hdb3_ber_checker
// BER checker for the recovered NRZ stream of the HDB3 link. A local replica
// of the transmit m-sequence self-synchronises to the received bits. Once it
// is locked, the block counts bit errors and drops back to SEARCH when too
// many errors fall in one window.
// Ports:
//   clk       in  1     : system clock
//   rst       in  1     : synchronous active-high reset
//   bit_en    in  1     : strobe marking a valid rx_bit
//   rx_bit    in  1     : decoded received bit
//   err_clr   in  1     : synchronous clear of err_cnt (and of bit_cnt)
//   locked    out 1     : replica aligned with the received stream
//   err_pulse out 1     : one-cycle pulse per mismatched bit while locked
//   bit_cnt   out 32    : bits seen while locked (only with HDB3_BER_BITCNT_EN)
//   err_cnt   out ERR_W : saturating count of errors seen while locked
// Build option: defining HDB3_BER_BITCNT_EN adds the bit_cnt port and its counter.
module hdb3_ber_checker
    import hdb3_pkg::*;
#(
    parameter int                LFSR_W   = HDB3_LFSR_W,
    parameter logic [LFSR_W-1:0] TAPS     = HDB3_TAPS,
    parameter int                LOCK_CNT = 16,
    parameter int                WIN      = 64,
    parameter int                LOSS_THR = 8,
    parameter int                ERR_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_en,
    input  logic             rx_bit,
    input  logic             err_clr,
    output logic             locked,
    output logic             err_pulse,
`ifdef HDB3_BER_BITCNT_EN
    output logic [31:0]      bit_cnt,
`endif
    output logic [ERR_W-1:0] err_cnt
);

    localparam int MW = $clog2(LOCK_CNT + 1);

    state_t            state;
    logic [LFSR_W-1:0] sr;
    logic [MW-1:0]     match_cnt;

    logic pred;
    logic hit;
    logic sr_nz;
    logic is_locked;
    logic lock_now;
    logic lock_err;
    logic loss;

    assign pred      = ^(sr & TAPS);
    assign hit       = (rx_bit == pred);
    // An all-zero register predicts zero forever, so it must never count as
    // a match. Otherwise an idle all-zero line would produce a false lock.
    assign sr_nz     = |sr;
    assign is_locked = (state == LOCKED);
    assign lock_now  = bit_en && !is_locked && hit && sr_nz &&
                       (match_cnt == MW'(LOCK_CNT - 1));
    assign lock_err  = bit_en && is_locked && !hit;
    assign locked    = is_locked;

    ber_window #(
        .WIN      (WIN),
        .LOSS_THR (LOSS_THR)
    ) u_window (
        .clk    (clk),
        .rst    (rst),
        .clear  (lock_now),
        .bit_en (bit_en && is_locked),
        .err    (!hit),
        .loss   (loss)
    );

    // NOTE: all state here is registered with non-blocking assignments, so
    // every branch reads the pre-edge values of sr, state and the counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SEARCH;
            sr        <= '0;
            match_cnt <= '0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
        end else begin
            err_pulse <= lock_err;

            if (bit_en) begin
                if (is_locked) begin
                    // Free-run on the prediction so that received errors
                    // never corrupt the replica.
                    sr <= {sr[LFSR_W-2:0], pred};
                    if (loss) begin
                        state     <= SEARCH;
                        match_cnt <= '0;
                    end
                end else begin
                    sr <= {sr[LFSR_W-2:0], rx_bit};
                    if (lock_now) begin
                        state     <= LOCKED;
                        match_cnt <= '0;
                    end else if (hit && sr_nz) begin
                        match_cnt <= match_cnt + 1'b1;
                    end else begin
                        match_cnt <= '0;
                    end
                end
            end

            // An error in the same cycle as the clear leaves a count of one.
            if (err_clr) begin
                err_cnt <= lock_err ? ERR_W'(1) : '0;
            end else if (lock_err && (err_cnt != '1)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

`ifdef HDB3_BER_BITCNT_EN
    always_ff @(posedge clk) begin
        if (rst || err_clr) begin
            bit_cnt <= '0;
        end else if (bit_en && is_locked) begin
            bit_cnt <= bit_cnt + 32'd1;
        end
    end
`endif

endmodule
